instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Main-controller state machine for the simple processor. Produces the 6-bit state code that drives control_unit, which registers one 20-bit control word per state.
- Steps fetch (fetch1–fetch3), decodes the opcode held in the IR, and runs the execute micro-sequence for LDR1, LDR2, STAC, ADD and MUL.
- Stalls on memory and multiplier handshakes.
- Provides start/halt control, error reporting and a retired-instruction count.

Parameters:
- OPC_W, 4, opcode width.
- WAIT_LIMIT, 255, maximum cycles spent in one wait state before a timeout error (legal range 1–65535).
- CNT_W, 16, width of instr_count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; leaves idle and begins fetching.
- opcode  in  OPC_W  IR opcode field; valid while state==fetch3.
- mem_ready  in  1  memory access complete; sampled only in memory wait states.
- mul_done  in  1  multiplier result valid; sampled only in mul.
- state  out  6  current state code, fed to control_unit.
- busy  out  1  high when state!=idle.
- halted  out  1  a HALT opcode was executed.
- error  out  1  an illegal opcode or a wait timeout occurred.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- State codes, fixed and matching control_unit:
  - idle=0, fetch1=1, fetch2=2, fetch3=3
  - ldr11..ldr14=4..7, ldr21..ldr24=8..11
  - stac1..stac4=12..15
  - add=16, add2=17, mul=18
  - No other code is ever driven.
- Reset (asynchronous, reset_n=0): state=idle, halted=0, error=0, instr_count=0, wait counter=0. busy follows state, so it is 0. Deasserting reset mid-instruction returns the FSM to idle; nothing resumes.
- idle:
  - start=1 -> fetch1 on the next edge; halted and error clear on that same edge.
  - start is ignored in every other state.
- Fetch:
  - fetch1 -> fetch2.
  - fetch2 is a wait state: -> fetch3 when mem_ready=1, else hold.
  - fetch3 -> decode target, chosen from the opcode sampled on the edge leaving fetch3.
- Decode targets:
  - 0 NOP -> fetch1 (retires).
  - 1 LDR1 -> ldr11.
  - 2 LDR2 -> ldr21.
  - 3 STAC -> stac1.
  - 4 ADD -> add.
  - 5 MUL -> mul.
  - 15 HALT -> idle, halted=1 (retires).
  - 6–14 -> idle, error=1 (does not retire).
- Execute sequences (no skipping):
  - LDR1: ldr11 -> ldr12 (wait on mem_ready) -> ldr13 -> ldr14 -> fetch1.
  - LDR2: ldr21 -> ldr22 (wait on mem_ready) -> ldr23 -> ldr24 -> fetch1.
  - STAC: stac1 -> stac2 (wait on mem_ready) -> stac3 -> stac4 -> fetch1.
  - ADD: add -> add2 -> fetch1.
  - MUL: mul holds until mul_done=1 -> fetch1.
- Wait states: fetch2, ldr12, ldr22, stac2, mul.
  - The wait counter clears on entry and increments each cycle the ready condition is low.
  - If ready is still low in the WAIT_LIMIT-th cycle spent in the state, the next state is idle and error=1.
  - Ready high in that same cycle wins: the FSM advances normally with no error.
  - Minimum wait cost is 1 cycle (ready already high on entry).
- Retirement: instr_count increments on every transition into fetch1 from ldr14, ldr24, stac4, add2, mul or NOP decode, and on HALT decode. It saturates at all-ones. It is not cleared by start.
- Latency: control_unit registers its output, so control_out reflects state one cycle later. Minimum cycles per instruction with zero-wait memory and multiplier:
  - NOP 3, ADD 5, MUL 4, LDR1/LDR2/STAC 7.
- Handshake inputs are ignored outside their own wait states. mem_ready held permanently high is legal.

Test Plan:
- Reset and start: hold reset_n=0 for 3 cycles -> state=0, busy=0, instr_count=0. Pulse start -> state sequence 1,2,3 with mem_ready=1.
- ADD then HALT, mem_ready=1: opcodes 4 then 15 -> states 1,2,3,16,17,1,2,3,0; instr_count=2, halted=1, busy=0.
- LDR1 with a memory stall: opcode 1, mem_ready held low 5 cycles in ldr12 -> ldr12 lasts 6 cycles, then 6,7,1; instr_count=1, error=0.
- MUL timeout (WAIT_LIMIT=4): opcode 5, mul_done=0 -> 4 cycles in state 18, then 0 with error=1, instr_count unchanged. A subsequent start clears error.
- Illegal opcode: opcode 9 at fetch3 -> idle, error=1, halted=0, count unchanged. start pulsed during a STAC sequence has no effect.
- Asynchronous reset mid-stac3: reset_n low mid-cycle -> state=0 immediately, before the next clock edge; all flags clear.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute state machine with handshake stalls, wait timeout, halt/error flags and retired count
module instr_sequencer #(
  parameter int OPC_W      = 4,
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  input  logic             mul_done,
  output logic [5:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [5:0] {
    IDLE, FETCH1, FETCH2, FETCH3,
    LDR11, LDR12, LDR13, LDR14,
    LDR21, LDR22, LDR23, LDR24,
    STAC1, STAC2, STAC3, STAC4,
    ADD, ADD2, MUL
  } state_t;
  state_t state_q, state_d;
  logic busy_q, halted_q, halted_d, error_q, error_d;
  logic retire, wait_st, rdy, timeout;
  logic [15:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    error_d  = error_q;
    retire   = 1'b0;
    wait_st  = state_q inside {FETCH2, LDR12, LDR22, STAC2, MUL};
    rdy      = (state_q == MUL) ? mul_done : mem_ready;
    timeout  = wait_st && !rdy && (wcnt_q == 16'(WAIT_LIMIT - 1));
    case (state_q)
      IDLE: if (start) begin
        state_d  = FETCH1;
        halted_d = 1'b0;
        error_d  = 1'b0;
      end
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = rdy ? FETCH3 : FETCH2;
      FETCH3: case (opcode)
        OPC_W'(0):  begin state_d = FETCH1; retire = 1'b1; end
        OPC_W'(1):  state_d = LDR11;
        OPC_W'(2):  state_d = LDR21;
        OPC_W'(3):  state_d = STAC1;
        OPC_W'(4):  state_d = ADD;
        OPC_W'(5):  state_d = MUL;
        OPC_W'(15): begin state_d = IDLE; halted_d = 1'b1; retire = 1'b1; end
        default:    begin state_d = IDLE; error_d = 1'b1; end
      endcase
      LDR11: state_d = LDR12;
      LDR12: state_d = rdy ? LDR13 : LDR12;
      LDR13: state_d = LDR14;
      LDR14: begin state_d = FETCH1; retire = 1'b1; end
      LDR21: state_d = LDR22;
      LDR22: state_d = rdy ? LDR23 : LDR22;
      LDR23: state_d = LDR24;
      LDR24: begin state_d = FETCH1; retire = 1'b1; end
      STAC1: state_d = STAC2;
      STAC2: state_d = rdy ? STAC3 : STAC2;
      STAC3: state_d = STAC4;
      STAC4: begin state_d = FETCH1; retire = 1'b1; end
      ADD:   state_d = ADD2;
      ADD2:  begin state_d = FETCH1; retire = 1'b1; end
      MUL:   begin state_d = rdy ? FETCH1 : MUL; retire = rdy; end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      error_d = 1'b1;
    end
    // counter only runs while stalled; any exit or entry leaves it at zero
    wcnt_d = (wait_st && !rdy && !timeout) ? wcnt_q + 16'd1 : 16'd0;
    cnt_d  = (retire && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      wcnt_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      halted_q <= halted_d;
      error_q  <= error_d;
      wcnt_q   <= wcnt_d;
      cnt_q    <= cnt_d;
    end
  end
  assign state       = state_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign error       = error_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized program run against an instruction-level model of the sequencer
module tb_instr_sequencer;
  localparam int LIM  = 8;
  localparam int CW   = 4;
  localparam int MAXC = 15;
  logic clock = 1'b0, reset_n = 1'b1, start = 1'b0, mem_ready = 1'b0, mul_done = 1'b0;
  logic [3:0] opcode = '0;
  logic [5:0] state;
  logic busy, halted, error;
  logic [CW-1:0] instr_count;
  int checks = 0, errors = 0, exp_cnt = 0;
  bit exp_err = 0, exp_halt = 0, ie;
  always #5 clock = ~clock;
  instr_sequencer #(.OPC_W(4), .WAIT_LIMIT(LIM), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .mem_ready(mem_ready), .mul_done(mul_done), .state(state), .busy(busy),
    .halted(halted), .error(error), .instr_count(instr_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic check_all(input int est);
    chk("state", 32'(state), est);
    chk("busy", 32'(busy), 32'(est != 0));
    chk("count", 32'(instr_count), exp_cnt);
    chk("error", 32'(error), 32'(exp_err));
    chk("halted", 32'(halted), 32'(exp_halt));
  endtask
  // one cycle: check expected state, then drive inputs (-1 = random don't-care)
  task automatic step(input int est, input int mr = -1, input int md = -1, input int st = -1, input int op = -1);
    @(negedge clock);
    check_all(est);
    mem_ready = (mr < 0) ? 1'($urandom) : 1'(mr);
    mul_done  = (md < 0) ? 1'($urandom) : 1'(md);
    start     = (st < 0) ? 1'($urandom) : 1'(st);
    opcode    = (op < 0) ? 4'($urandom) : 4'(op);
  endtask
  task automatic retire();
    exp_cnt = (exp_cnt < MAXC) ? exp_cnt + 1 : exp_cnt;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, -1, -1, 0, -1);
  endtask
  task automatic do_start();
    step(0, -1, -1, 1, -1);
    exp_err  = 0;
    exp_halt = 0;
  endtask
  task automatic wait_on(input int st, input int lows, input bit is_mul, output bit to);
    to = 0;
    for (int i = 0; i < LIM; i++) begin
      if (is_mul) step(st, -1, int'(i >= lows), -1, -1);
      else        step(st, int'(i >= lows), -1, -1, -1);
      if (i >= lows) return;
    end
    to = 1;
    exp_err = 1;
  endtask
  task automatic exec(input int op, input int wf, input int ww, output bit ends_idle);
    bit to;
    int b;
    ends_idle = 0;
    step(1);
    wait_on(2, wf, 0, to);
    if (to) begin ends_idle = 1; return; end
    step(3, -1, -1, -1, op);
    b = (op == 1) ? 4 : (op == 2) ? 8 : 12;
    case (op)
      0: retire();
      1, 2, 3: begin
        step(b);
        wait_on(b + 1, ww, 0, to);
        if (to) begin ends_idle = 1; return; end
        step(b + 2);
        step(b + 3);
        retire();
      end
      4: begin step(16); step(17); retire(); end
      5: begin
        wait_on(18, ww, 1, to);
        if (to) ends_idle = 1;
        else retire();
      end
      15: begin exp_halt = 1; retire(); ends_idle = 1; end
      default: begin exp_err = 1; ends_idle = 1; end
    endcase
  endtask
  initial begin
    int r, op;
    bit to;
    #1 reset_n = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    idle(1);
    do_start();
    exec(4, 0, 0, ie);
    exec(15, 0, 0, ie);
    idle(2);
    do_start();
    exec(1, 0, 5, ie);
    exec(0, 1, 0, ie);
    exec(15, 2, 0, ie);
    do_start();
    exec(5, 0, LIM, ie);
    idle(2);
    do_start();
    exec(9, 0, 0, ie);
    idle(1);
    do_start();
    exec(3, 0, 2, ie);
    exec(5, 0, LIM - 1, ie);
    exec(2, 3, LIM - 1, ie);
    exec(0, LIM, 0, ie);
    ie = 1;
    repeat (40) begin
      if (ie) begin idle(1); do_start(); end
      r  = $urandom_range(0, 19);
      op = (r < 15) ? r % 6 : (r < 18) ? 15 : (r == 18) ? 7 : 14;
      exec(op, $urandom_range(0, 2), $urandom_range(0, 3), ie);
    end
    if (ie) begin idle(1); do_start(); end
    exec(4, 0, 0, ie);
    step(1);
    wait_on(2, 0, 0, to);
    step(3, -1, -1, -1, 3);
    step(12);
    wait_on(13, 1, 0, to);
    step(14);
    #2 reset_n = 1'b0;
    #1 exp_cnt = 0;
    exp_err  = 0;
    exp_halt = 0;
    check_all(0);
    @(negedge clock);
    start   = 1'b0;
    reset_n = 1'b1;
    idle(2);
    do_start();
    exec(4, 0, 0, ie);
    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
